// File: rtl/block_xfer_sequencer_pkg.sv
// Shared definitions for the LDM/STM block-transfer sequencer:
// FSM state encoding, addressing-mode encodings of {P,U}, the default
// word stride, and the helper that computes the offset of the first word.
package leg_uop_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WB   = 2'd2
    } seq_state_e;

    // Encoded as {P,U} taken straight from the instruction.
    typedef enum logic [1:0] {
        AM_DA = 2'b00,
        AM_IA = 2'b01,
        AM_DB = 2'b10,
        AM_IB = 2'b11
    } addr_mode_e;

    localparam int WORD_BYTES_DEFAULT = 4;

    // Offset of the lowest-numbered register relative to the original base.
    // Registers always go out in ascending order, so the decrementing modes
    // start below the base and walk upward.
    function automatic logic [31:0] initial_offset(addr_mode_e mode,
                                                   logic [4:0] n,
                                                   logic [31:0] stride);
        logic [31:0] n_bytes;
        n_bytes = {27'd0, n} * stride;
        case (mode)
            AM_IA:   initial_offset = 32'd0;
            AM_IB:   initial_offset = stride;
            AM_DA:   initial_offset = stride - n_bytes;  // -(N-1)*stride
            default: initial_offset = 32'd0 - n_bytes;   // DB: -N*stride
        endcase
    endfunction

endpackage

// File: rtl/block_xfer_sequencer_if.sv
// Bus between the decode stage and the block-transfer sequencer.
//   InstrD/StartValid/StartReady : instruction start handshake
//   FlushE                       : pipeline flush
//   UopValid/UopReady + Uop*     : micro-op output handshake
//   Busy                         : sequencer not idle
// master = upstream/downstream pipeline side, slave = sequencer.
interface block_xfer_sequencer_if;
    logic [31:0] InstrD;
    logic        StartValid;
    logic        StartReady;
    logic        FlushE;
    logic        UopValid;
    logic        UopReady;
    logic [3:0]  UopRd;
    logic [3:0]  UopRn;
    logic [31:0] UopOffset;
    logic        UopLoad;
    logic        UopWb;
    logic        UopLast;
    logic        Busy;

    modport master (
        output InstrD, StartValid, FlushE, UopReady,
        input  StartReady, UopValid, UopRd, UopRn, UopOffset,
               UopLoad, UopWb, UopLast, Busy
    );

    modport slave (
        input  InstrD, StartValid, FlushE, UopReady,
        output StartReady, UopValid, UopRd, UopRn, UopOffset,
               UopLoad, UopWb, UopLast, Busy
    );
endinterface

// File: rtl/block_xfer_sequencer_lsb_reg_picker.sv
// Combinational lowest-set-bit picker for a 16-bit register list.
//   list_i  : register list
//   idx_o   : index of the lowest set bit (0 when the list is empty)
//   rest_o  : list_i with that bit cleared
//   empty_o : list_i has no bits set
module lsb_reg_picker (
    input  logic [15:0] list_i,
    output logic [3:0]  idx_o,
    output logic [15:0] rest_o,
    output logic        empty_o
);
    always_comb begin
        // NOTE: default assignment first so no path leaves idx_o unassigned (no latch).
        idx_o = 4'd0;
        // Scan downward so the lowest set bit is the last (winning) write.
        for (int i = 15; i >= 0; i--) begin
            if (list_i[i]) idx_o = 4'(i);
        end
    end

    assign rest_o  = list_i & (list_i - 16'd1);
    assign empty_o = (list_i == 16'd0);
endmodule

// File: rtl/block_xfer_sequencer.sv
// LDM/STM block-transfer sequencer: accepts one decoded block-transfer
// instruction and emits one transfer micro-op per listed register in
// ascending order, followed by an optional base-writeback micro-op.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : block_xfer_sequencer_if.slave (start handshake, flush, uop stream)
module block_xfer_sequencer
    import leg_uop_pkg::*;
#(
    parameter int WORD_BYTES = WORD_BYTES_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    block_xfer_sequencer_if.slave    bus
);
    localparam logic [31:0] STRIDE = 32'(WORD_BYTES);

    seq_state_e  state_q;
    logic [15:0] list_q;
    logic [31:0] offset_q;
    logic [4:0]  n_q;
    logic [3:0]  rn_q;
    logic        load_q;
    logic        wb_en_q;
    logic        up_q;
    logic        ready_q;

    logic [4:0]  pop_d;
    logic [15:0] pick_list;
    logic [3:0]  pick_idx;
    logic [15:0] pick_rest;
    logic        pick_empty;
    logic [31:0] n_bytes;
    logic        last_xfer;
    logic        unused_instr_bits;

    // S bit and the condition/opcode bits are not this block's concern.
    assign unused_instr_bits = ^{bus.InstrD[31:25], bus.InstrD[22]};

    always_comb begin
        pop_d = 5'd0;
        for (int i = 0; i < 16; i++) begin
            pop_d = pop_d + 5'(bus.InstrD[i]);
        end
    end

    // In IDLE the picker looks at the incoming list so an empty list can be
    // spotted at acceptance; otherwise it walks the captured list.
    assign pick_list = (state_q == IDLE) ? bus.InstrD[15:0] : list_q;

    lsb_reg_picker u_picker (
        .list_i  (pick_list),
        .idx_o   (pick_idx),
        .rest_o  (pick_rest),
        .empty_o (pick_empty)
    );

    assign n_bytes   = {27'd0, n_q} * STRIDE;
    assign last_xfer = (pick_rest == 16'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q  <= IDLE;
            list_q   <= 16'd0;
            offset_q <= 32'd0;
            n_q      <= 5'd0;
            rn_q     <= 4'd0;
            load_q   <= 1'b0;
            wb_en_q  <= 1'b0;
            up_q     <= 1'b0;
            ready_q  <= 1'b0;
        end else if (bus.FlushE) begin
            // Flush wins over any handshake in the same cycle.
            state_q <= IDLE;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (bus.StartValid && ready_q) begin
                        list_q   <= bus.InstrD[15:0];
                        rn_q     <= bus.InstrD[19:16];
                        load_q   <= bus.InstrD[20];
                        wb_en_q  <= bus.InstrD[21];
                        up_q     <= bus.InstrD[23];
                        n_q      <= pop_d;
                        offset_q <= initial_offset(addr_mode_e'(bus.InstrD[24:23]),
                                                   pop_d, STRIDE);
                        // An empty list is consumed without leaving IDLE.
                        if (!pick_empty) begin
                            state_q <= XFER;
                            ready_q <= 1'b0;
                        end
                    end
                end
                XFER: begin
                    if (bus.UopReady) begin
                        list_q   <= pick_rest;
                        offset_q <= offset_q + STRIDE;
                        if (last_xfer) begin
                            if (wb_en_q) begin
                                state_q  <= WB;
                                offset_q <= up_q ? n_bytes : (32'd0 - n_bytes);
                            end else begin
                                state_q <= IDLE;
                                ready_q <= 1'b1;
                            end
                        end
                    end
                end
                WB: begin
                    if (bus.UopReady) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.StartReady = ready_q;
    assign bus.Busy       = (state_q != IDLE);
    assign bus.UopValid   = (state_q != IDLE);
    assign bus.UopWb      = (state_q == WB);
    assign bus.UopLast    = (state_q == WB) || ((state_q == XFER) && last_xfer && !wb_en_q);
    assign bus.UopRd      = (state_q == XFER) ? pick_idx : 4'd0;
    assign bus.UopRn      = rn_q;
    assign bus.UopOffset  = offset_q;
    assign bus.UopLoad    = load_q;
endmodule

// File: tb/tb_block_xfer_sequencer.sv
module tb_block_xfer_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    block_xfer_sequencer_if bus ();

    block_xfer_sequencer #(.WORD_BYTES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_uop(input string tag, input logic v, input logic [3:0] rd,
                             input logic [31:0] off, input logic wb, input logic last);
        check({tag, ".valid"},  32'(bus.UopValid),  32'(v));
        check({tag, ".rd"},     32'(bus.UopRd),     32'(rd));
        check({tag, ".offset"}, bus.UopOffset,      off);
        check({tag, ".wb"},     32'(bus.UopWb),     32'(wb));
        check({tag, ".last"},   32'(bus.UopLast),   32'(last));
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, 32'(bus.UopValid),   32'd0);
        check({tag, ".busy"},  32'(bus.Busy),       32'd0);
        check({tag, ".ready"}, 32'(bus.StartReady), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".valid"},  32'(bus.UopValid),   32'd0);
        check({tag, ".busy"},   32'(bus.Busy),       32'd0);
        check({tag, ".wb"},     32'(bus.UopWb),      32'd0);
        check({tag, ".last"},   32'(bus.UopLast),    32'd0);
        check({tag, ".rd"},     32'(bus.UopRd),      32'd0);
        check({tag, ".rn"},     32'(bus.UopRn),      32'd0);
        check({tag, ".offset"}, bus.UopOffset,       32'd0);
        check({tag, ".load"},   32'(bus.UopLoad),    32'd0);
        check({tag, ".ready"},  32'(bus.StartReady), 32'd0);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b0;
        bus.InstrD     = 32'd0;
        bus.StartValid = 1'b0;
        bus.FlushE     = 1'b0;
        bus.UopReady   = 1'b0;

        // Reset state
        repeat (2) tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();
        check_idle("post_reset");

        // LDMIA Rn=3 list=0x8005 W=0
        bus.UopReady   = 1'b1;
        bus.InstrD     = 32'h0093_8005;
        bus.StartValid = 1'b1;
        tick();
        bus.StartValid = 1'b0;
        check_uop("ldmia0", 1'b1, 4'd0, 32'd0, 1'b0, 1'b0);
        check("ldmia0.rn",    32'(bus.UopRn),      32'd3);
        check("ldmia0.load",  32'(bus.UopLoad),    32'd1);
        check("ldmia0.busy",  32'(bus.Busy),       32'd1);
        check("ldmia0.ready", 32'(bus.StartReady), 32'd0);
        tick();
        check_uop("ldmia1", 1'b1, 4'd2, 32'd4, 1'b0, 1'b0);
        tick();
        check_uop("ldmia2", 1'b1, 4'd15, 32'd8, 1'b0, 1'b1);
        tick();
        check_idle("ldmia_done");

        // STMDB Rn=13 list=0x00F0 W=1
        bus.InstrD     = 32'h012D_00F0;
        bus.StartValid = 1'b1;
        tick();
        bus.StartValid = 1'b0;
        check_uop("stmdb0", 1'b1, 4'd4, 32'hFFFF_FFF0, 1'b0, 1'b0);
        check("stmdb0.load", 32'(bus.UopLoad), 32'd0);
        check("stmdb0.rn",   32'(bus.UopRn),   32'd13);
        tick();
        check_uop("stmdb1", 1'b1, 4'd5, 32'hFFFF_FFF4, 1'b0, 1'b0);
        tick();
        check_uop("stmdb2", 1'b1, 4'd6, 32'hFFFF_FFF8, 1'b0, 1'b0);
        tick();
        check_uop("stmdb3", 1'b1, 4'd7, 32'hFFFF_FFFC, 1'b0, 1'b0);
        tick();
        check_uop("stmdb_wb", 1'b1, 4'd0, 32'hFFFF_FFF0, 1'b1, 1'b1);
        check("stmdb_wb.ready", 32'(bus.StartReady), 32'd0);
        tick();
        check_idle("stmdb_done");

        // LDMIB Rn=1 list=0x0003, downstream stalls 3 cycles on the first uop
        bus.UopReady   = 1'b0;
        bus.InstrD     = 32'h0191_0003;
        bus.StartValid = 1'b1;
        tick();
        bus.StartValid = 1'b0;
        check_uop("ldmib_stall0", 1'b1, 4'd0, 32'd4, 1'b0, 1'b0);
        tick();
        check_uop("ldmib_stall1", 1'b1, 4'd0, 32'd4, 1'b0, 1'b0);
        tick();
        check_uop("ldmib_stall2", 1'b1, 4'd0, 32'd4, 1'b0, 1'b0);
        bus.UopReady = 1'b1;
        tick();
        check_uop("ldmib1", 1'b1, 4'd1, 32'd8, 1'b0, 1'b1);
        tick();
        check_idle("ldmib_done");

        // Empty list (S bit set, ignored)
        bus.InstrD     = 32'h00D0_0000;
        bus.StartValid = 1'b1;
        tick();
        bus.StartValid = 1'b0;
        check_idle("empty0");
        tick();
        check_idle("empty1");

        // LDMDA Rn=2 list=0xFFFF, flushed while the 2nd uop is presented
        bus.InstrD     = 32'h0012_FFFF;
        bus.StartValid = 1'b1;
        tick();
        bus.StartValid = 1'b0;
        check_uop("ldmda0", 1'b1, 4'd0, 32'hFFFF_FFC4, 1'b0, 1'b0);
        tick();
        check_uop("ldmda1", 1'b1, 4'd1, 32'hFFFF_FFC8, 1'b0, 1'b0);
        bus.FlushE = 1'b1;
        tick();
        bus.FlushE = 1'b0;
        check_idle("flush");
        // Next instruction after flush: LDMIA Rn=0 list=0x0002
        bus.InstrD     = 32'h0090_0002;
        bus.StartValid = 1'b1;
        tick();
        bus.StartValid = 1'b0;
        check_uop("post_flush", 1'b1, 4'd1, 32'd0, 1'b0, 1'b1);
        check("post_flush.rn", 32'(bus.UopRn), 32'd0);
        tick();
        check_idle("post_flush_done");

        // STMIA Rn=4 list=0x0011 W=1, reset pulsed mid-XFER
        bus.InstrD     = 32'h00A4_0011;
        bus.StartValid = 1'b1;
        tick();
        bus.StartValid = 1'b0;
        check_uop("stmia0", 1'b1, 4'd0, 32'd0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        tick();
        check_all_zero("mid_reset_held");
        reset = 1'b1;
        tick();
        check_idle("reset_release");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
